// File: rtl/uart_boot_loader_pkg.sv
// Shared constants and state encodings for the UART boot loader.
package minisys_pkg;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   typedef enum logic [2:0] {
      LD_WAIT_SYNC,
      LD_LEN_LO,
      LD_LEN_HI,
      LD_DATA,
      LD_CSUM,
      LD_DONE
   } loader_state_t;

endpackage

// File: rtl/uart_boot_loader_if.sv
// Instruction-memory write port plus CPU reset and loader status.
interface uart_boot_loader_if #(parameter int IMEM_AW = 14);

   logic               imem_we;
   logic [IMEM_AW-1:0] imem_waddr;
   logic [31:0]        imem_wdata;
   logic               cpu_rst;
   logic               busy;
   logic               err;

   modport master (output imem_we, imem_waddr, imem_wdata, cpu_rst, busy, err);
   modport slave  (input  imem_we, imem_waddr, imem_wdata, cpu_rst, busy, err);

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with a 2-FF input synchronizer.
// Latency: byte_valid about 9.5 bit times after the start edge plus 3 cycles.
// No backpressure: byte_valid/frame_err are single-cycle pulses.
module uart_rx_byte
   import minisys_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       uart_rx,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err
);

   localparam int            CW        = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   rx_state_t     state, state_nxt;
   logic          rx_meta, rx_sync, rx_prev;
   logic [CW-1:0] cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          half_tick, full_tick;

   assign half_tick = (cnt == HALF_LAST);
   assign full_tick = (cnt == FULL_LAST);
   assign byte_data = shreg;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
      end else begin
         rx_meta <= uart_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         state   <= state_nxt;
         // Bit timer restarts on every state change and at each full bit period.
         if (state_nxt != state || full_tick) cnt <= '0;
         else                                 cnt <= cnt + 1'b1;
         if (state == RX_START) bit_idx <= '0;
         if (state == RX_DATA && full_tick) begin
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (state)
         RX_IDLE:  if (rx_prev && !rx_sync) state_nxt = RX_START;
         RX_START: if (half_tick) state_nxt = rx_sync ? RX_IDLE : RX_DATA;
         RX_DATA:  if (full_tick && bit_idx == 3'd7) state_nxt = RX_STOP;
         RX_STOP: begin
            if (full_tick) begin
               state_nxt  = RX_IDLE;
               byte_valid = rx_sync;
               frame_err  = !rx_sync;
            end
         end
         default:  state_nxt = RX_IDLE;
      endcase
   end

endmodule

// File: rtl/uart_boot_loader.sv
// Loads a sync/length/data/checksum UART frame into instruction memory.
// Latency: imem write and cpu_rst/err updates 1 cycle after the causing byte.
// No backpressure: memory must accept a write every cycle imem_we is high.
module uart_boot_loader
   import minisys_pkg::*;
#(
   parameter int CLK_HZ  = 100000000,
   parameter int BAUD    = 115200,
   parameter int IMEM_AW = 14
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               uart_rx,
   uart_boot_loader_if.master bus
);

   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

   loader_state_t      state, state_nxt;
   logic               byte_valid, frame_err;
   logic [7:0]         byte_data;
   logic [15:0]        len;
   logic [IMEM_AW-1:0] addr;
   logic [1:0]         byte_idx;
   logic [31:0]        word;
   logic [7:0]         csum;
   logic               abort;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk        (clk),
      .rst        (rst),
      .uart_rx    (uart_rx),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (frame_err)
   );

   assign abort = frame_err && state != LD_WAIT_SYNC && state != LD_DONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= LD_WAIT_SYNC;
         len            <= '0;
         addr           <= '0;
         byte_idx       <= '0;
         word           <= '0;
         csum           <= '0;
         bus.imem_we    <= 1'b0;
         bus.imem_waddr <= '0;
         bus.imem_wdata <= '0;
         bus.cpu_rst    <= 1'b1;
         bus.busy       <= 1'b0;
         bus.err        <= 1'b0;
      end else begin
         state       <= state_nxt;
         bus.imem_we <= 1'b0;
         if (abort) begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
         end else if (byte_valid) begin
            case (state)
               LD_WAIT_SYNC: if (byte_data == SYNC_BYTE) begin
                  bus.err  <= 1'b0;
                  bus.busy <= 1'b1;
                  addr     <= '0;
                  byte_idx <= '0;
                  csum     <= '0;
               end
               LD_LEN_LO: len[7:0]  <= byte_data;
               LD_LEN_HI: len[15:8] <= byte_data;
               LD_DATA: begin
                  csum     <= csum ^ byte_data;
                  byte_idx <= byte_idx + 1'b1;
                  word[{byte_idx, 3'b000} +: 8] <= byte_data;
                  if (byte_idx == 2'd3) begin
                     bus.imem_we    <= 1'b1;
                     bus.imem_waddr <= addr;
                     bus.imem_wdata <= {byte_data, word[23:0]};
                     addr           <= addr + 1'b1;
                     len            <= len - 16'd1;
                  end
               end
               LD_CSUM: begin
                  bus.busy <= 1'b0;
                  if (byte_data == csum) bus.cpu_rst <= 1'b0;
                  else                   bus.err     <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = LD_WAIT_SYNC;
      end else if (byte_valid) begin
         case (state)
            LD_WAIT_SYNC: if (byte_data == SYNC_BYTE) state_nxt = LD_LEN_LO;
            LD_LEN_LO:    state_nxt = LD_LEN_HI;
            LD_LEN_HI:    state_nxt = ({byte_data, len[7:0]} == 16'd0) ? LD_CSUM : LD_DATA;
            LD_DATA:      if (byte_idx == 2'd3 && len == 16'd1) state_nxt = LD_CSUM;
            LD_CSUM:      state_nxt = (byte_data == csum) ? LD_DONE : LD_WAIT_SYNC;
            LD_DONE:      state_nxt = LD_DONE;
            default:      state_nxt = LD_WAIT_SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench: expected writes are queued with the stimulus, a monitor checks each imem_we.
module tb_uart_boot_loader;
   import minisys_pkg::*;

   localparam int CPB = 16;
   localparam int AW  = 14;

   logic clk     = 1'b0;
   logic rst     = 1'b1;
   logic uart_rx = 1'b1;

   always #5 clk = ~clk;

   uart_boot_loader_if #(.IMEM_AW(AW)) bus ();

   uart_boot_loader #(.CLK_HZ(16), .BAUD(1), .IMEM_AW(AW)) dut (
      .clk     (clk),
      .rst     (rst),
      .uart_rx (uart_rx),
      .bus     (bus)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [31:0]   data;
   } wr_t;

   wr_t  exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   int   fall_cyc = -1;
   int   rise_cyc = -1;
   logic prev_cpu_rst = 1'b1;
   logic prev_err = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      if (!rst && bus.imem_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                     bus.imem_waddr, bus.imem_wdata);
         end else begin
            e = exp_q.pop_front();
            check("write_addr", 32'(bus.imem_waddr), 32'(e.addr));
            check("write_data", bus.imem_wdata, e.data);
         end
      end
      if (prev_cpu_rst && !bus.cpu_rst) fall_cyc = cyc;
      if (!prev_err && bus.err) rise_cyc = cyc;
      prev_cpu_rst = bus.cpu_rst;
      prev_err     = bus.err;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst     = 1'b1;
      uart_rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      @(posedge clk);
      #1;
      start_cyc = cyc;
      uart_rx   = 1'b0;
      repeat (CPB) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
      uart_rx = stop;
      repeat (CPB) @(posedge clk);
      #1;
      uart_rx = 1'b1;
      if (!stop) begin
         repeat (2 * CPB) @(posedge clk);
         #1;
      end
   endtask

   task automatic send_frame(input logic [7:0] csum, input int lo, input int hi);
      logic [7:0] f [12];
      f = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
            8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00};
      f[11] = csum;
      for (int i = lo; i <= hi; i++) send_byte(f[i], 1'b1);
   endtask

   task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a;
      w.data = d;
      exp_q.push_back(w);
   endtask

   task automatic push_frame_writes();
      push_wr(14'd0, 32'h12345678);
      push_wr(14'd1, 32'hDEADBEEF);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_imem_we"},    32'(bus.imem_we), 32'd0);
      check({tag, "_imem_waddr"}, 32'(bus.imem_waddr), 32'd0);
      check({tag, "_imem_wdata"}, bus.imem_wdata, 32'd0);
      check({tag, "_cpu_rst"},    32'(bus.cpu_rst), 32'd1);
      check({tag, "_busy"},       32'(bus.busy), 32'd0);
      check({tag, "_err"},        32'(bus.err), 32'd0);
   endtask

   task automatic check_loaded(input string tag);
      check({tag, "_cpu_rst"}, 32'(bus.cpu_rst), 32'd0);
      check({tag, "_busy"},    32'(bus.busy), 32'd0);
      check({tag, "_err"},     32'(bus.err), 32'd0);
      check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      do_reset();
      check_reset("reset");

      // Bad checksum: both words still land, err rises one cycle after the byte
      push_frame_writes();
      send_frame(8'h00, 0, 11);
      check("badcsum_err", 32'(bus.err), 32'd1);
      check("badcsum_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      check("badcsum_busy", 32'(bus.busy), 32'd0);
      check("badcsum_err_delay", 32'(rise_cyc - start_cyc), 32'd155);
      check("badcsum_pending", 32'(exp_q.size()), 32'd0);

      push_frame_writes();
      send_frame(8'h2A, 0, 11);
      check_loaded("resend");
      check("resend_release_delay", 32'(fall_cyc - start_cyc), 32'd155);

      // Loaded: a further frame must be ignored entirely
      send_frame(8'h2A, 0, 11);
      check("done_ignore_cpu_rst", 32'(bus.cpu_rst), 32'd0);

      // Leading junk before the sync byte
      do_reset();
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h13, 1'b1);
      check("junk_busy", 32'(bus.busy), 32'd0);
      push_frame_writes();
      send_frame(8'h2A, 0, 11);
      check_loaded("junk");

      // Zero-length image
      do_reset();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h00, 1'b1);
      send_byte(8'h00, 1'b1);
      check("zero_cpu_rst_before", 32'(bus.cpu_rst), 32'd1);
      send_byte(8'h00, 1'b1);
      check_loaded("zero");
      check("zero_release_delay", 32'(fall_cyc - start_cyc), 32'd155);

      // Framing error mid-word, then a short low glitch mid-frame
      do_reset();
      send_frame(8'h2A, 0, 3);
      send_byte(8'h56, 1'b0);
      check("framing_err", 32'(bus.err), 32'd1);
      check("framing_busy", 32'(bus.busy), 32'd0);
      check("framing_cpu_rst", 32'(bus.cpu_rst), 32'd1);
      send_frame(8'h2A, 0, 0);
      check("resync_busy", 32'(bus.busy), 32'd1);
      check("resync_err", 32'(bus.err), 32'd0);
      uart_rx = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      uart_rx = 1'b1;
      repeat (40) @(posedge clk);
      #1;
      check("glitch_busy", 32'(bus.busy), 32'd1);
      push_frame_writes();
      send_frame(8'h2A, 1, 11);
      check_loaded("glitch");

      // Reset after five data bytes, then a clean reload from address 0
      do_reset();
      push_wr(14'd0, 32'h12345678);
      send_frame(8'h2A, 0, 7);
      check("partial_busy", 32'(bus.busy), 32'd1);
      check("partial_pending", 32'(exp_q.size()), 32'd0);
      do_reset();
      check_reset("midreset");
      push_frame_writes();
      send_frame(8'h2A, 0, 11);
      check_loaded("reload");

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Serial program loader sitting directly upstream of the MiniSys-1A instruction memory. It receives a framed binary image on the board UART RX pin and writes it word-by-word into instruction memory starting at word 0. It holds the CPU core in reset until a complete image with a valid checksum has been written. It replaces manual `$readmemh` preloading on hardware.

## Interface
- `CLK_HZ`, 100000000, system clock frequency in Hz
- `BAUD`, 115200, UART bit rate; `CLKS_PER_BIT = CLK_HZ / BAUD` (integer division, must be ≥ 4)
- `IMEM_AW`, 14, instruction memory word-address width (16384 words)

Ports:
- `clk` in 1: the single system clock
- `rst` in 1: reset, synchronous, active-high
- `uart_rx` in 1: asynchronous serial input, idle high, 8N1, LSB first
- `imem_we` out 1: one-cycle instruction-memory write strobe
- `imem_waddr` out `IMEM_AW`: word address for the write
- `imem_wdata` out 32: word to write
- `cpu_rst` out 1: reset to `cpu_core`, high until the load completes
- `busy` out 1: high while a frame is in progress
- `err` out 1: sticky error flag

## Operation
- **Input sync:** `uart_rx` passes through a 2-FF synchronizer before any use.
- **RX FSM** (`IDLE`, `START`, `DATA`, `STOP`):
  - `IDLE`: a synchronized falling edge moves to `START`.
  - `START`: wait `CLKS_PER_BIT/2` cycles, then sample. Low goes to `DATA`. High is a glitch: return to `IDLE` with no byte.
  - `DATA`: sample 8 bits, one every `CLKS_PER_BIT`, LSB first.
  - `STOP`: after `CLKS_PER_BIT`, sample the stop bit. 1 produces a one-cycle `byte_valid` with `byte_data`. 0 produces a one-cycle `frame_err`. Either way return to `IDLE`.
- **Loader FSM** (`WAIT_SYNC`, `LEN_LO`, `LEN_HI`, `DATA`, `CSUM`, `DONE`):
  - `WAIT_SYNC`: bytes other than `0xA5` are ignored. On `0xA5`: clear `err`, address, byte index and checksum; set `busy`; go to `LEN_LO`.
  - `LEN_LO` / `LEN_HI`: capture a 16-bit word count N, little-endian. N=0 goes straight to `CSUM`.
  - `DATA`: assemble bytes little-endian; byte k fills bits `[8k+7:8k]`. The running checksum is the XOR of every data byte. On the 4th byte, issue the write, increment the address, decrement N. When N reaches 0, go to `CSUM`.
  - `CSUM`: if the received byte equals the running XOR, go to `DONE` and drop `busy`. On mismatch, set `err`, drop `busy`, return to `WAIT_SYNC`; `cpu_rst` stays 1.
  - `DONE`: `cpu_rst`=0. All further bytes are ignored until `rst`.
- **Framing error:** `frame_err` in any state other than `WAIT_SYNC`/`DONE` sets `err`, drops `busy`, and returns to `WAIT_SYNC`. The partial word is discarded. Words already written are not rolled back.
- **Address wrap:** `imem_waddr` wraps modulo 2^`IMEM_AW` when N exceeds the memory size.

## Timing
- **Reset values:** `imem_we`=0, `imem_waddr`=0, `imem_wdata`=0, `cpu_rst`=1, `busy`=0, `err`=0. All internal FSMs go to `IDLE`/`WAIT_SYNC`.
- **Reset mid-frame:** aborts fully; the next load starts at address 0.
- **`byte_valid`:** asserts `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles (±1) after the synchronized start edge, plus 2 cycles of synchronizer delay.
- **Write:** `imem_we` is registered and asserts exactly 1 cycle after the 4th data byte's `byte_valid`. `imem_waddr`/`imem_wdata` are valid in that same cycle and hold until the next write.
- **Completion:** `cpu_rst` falls 1 cycle after `byte_valid` of a matching checksum byte. `err` rises 1 cycle after the mismatch or `frame_err`.
- **Back-to-back frames:** a new start edge may arrive in the cycle after the stop-bit sample without any byte being lost.

## Structure
- **Package `minisys_pkg`:** `SYNC_BYTE = 8'hA5`, the `rx_state_t` and `loader_state_t` enums.
- **Sub-module `uart_rx_byte`:** synchronizer plus RX FSM, with outputs `byte_valid`, `byte_data[7:0]`, `frame_err`.
- **`uart_boot_loader`:** contains the loader FSM, word assembly and checksum.

## Test plan
All scenarios use `CLK_HZ`=16, `BAUD`=1, giving 16 clocks/bit.
1. Send `A5 02 00 78 56 34 12 EF BE AD DE 2A` -> writes `0x12345678` at address 0 and `0xDEADBEEF` at address 1, one `imem_we` pulse each. Then `cpu_rst` 1→0, `busy` 1→0, `err`=0.
2. Same frame with checksum `00` -> both writes occur, `err`=1, `cpu_rst` stays 1. Resending the frame from scenario 1 clears `err` and releases `cpu_rst`.
3. Send `00 FF 13` before scenario 1's frame -> leading bytes ignored; identical outcome to scenario 1.
4. Send `A5 00 00 00` -> no `imem_we` pulses; `cpu_rst` falls 1 cycle after the last byte.
5. Drive a data byte with stop bit 0 -> `err`=1, `busy`=0, FSM in `WAIT_SYNC`. A `uart_rx` low glitch of 3 clocks -> no byte, no state change.
6. Assert `rst` after 5 data bytes, then send scenario 1's frame -> first write is at address 0, and the result matches scenario 1.
